// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result path: drain FSM encoding and
// result-memory timing.
package mac_pkg;

  // Drain controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    D_IDLE    = 2'b00,
    D_READ    = 2'b01,
    D_CAPTURE = 2'b10,
    D_STREAM  = 2'b11
  } drain_state_t;

  // Result memory returns read data this many cycles after c_re.
  localparam int C_RD_LATENCY = 1;

endpackage

// File: rtl/mac_result_drain_if.sv
// Element stream produced by the result drain: one C element per
// valid/ready beat, tagged with its row-major index and a last flag.
interface mac_result_drain_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
);

  logic                  out_val;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;

  // Producer side (the drain).
  modport master (
    output out_val,
    output out_data,
    output out_idx,
    output out_last,
    input  out_rdy
  );

  // Consumer side.
  modport slave (
    input  out_val,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_rdy
  );

endinterface

// File: rtl/mac_result_drain.sv
// Result drain for the MAC top. Reads the whole C memory once, snapshots it
// into a shadow register while acknowledging the MAC top (so the MAC can go
// back to IDLE), then streams the snapshot one element per beat in
// row-major order. All outputs decode from registered state only.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int  param_M          = 4,
  parameter int  param_N          = 4,
  parameter int  DATA_WIDTH_FINAL = 16,
  localparam int ELEMS            = param_M * param_N,
  localparam int IDX_W            = $clog2(ELEMS)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              blk_val,
  output logic                              blk_rdy,
  output logic                              c_re,
  input  logic [ELEMS*DATA_WIDTH_FINAL-1:0] c_data_in,
  output logic                              busy,
  mac_result_drain_if.master                stream
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  drain_state_t                      state_r;
  drain_state_t                      state_s;
  logic [IDX_W-1:0]                  idx_r;
  logic [IDX_W-1:0]                  idx_s;
  logic                              load_s;
  logic [ELEMS*DATA_WIDTH_FINAL-1:0] shadow_r;
  logic                              streaming_s;

  // Next-state and index update; the shadow load strobe fires only in CAPTURE,
  // which is the cycle the memory data is valid after the one-cycle read.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    load_s  = 1'b0;
    case (state_r)
      D_IDLE: begin
        if (blk_val) begin
          state_s = D_READ;
        end else begin
          state_s = D_IDLE;
        end
      end
      D_READ: begin
        state_s = D_CAPTURE;
      end
      D_CAPTURE: begin
        load_s  = 1'b1;
        idx_s   = {IDX_W{1'b0}};
        state_s = D_STREAM;
      end
      D_STREAM: begin
        if (stream.out_rdy) begin
          if (idx_r == LAST_IDX) begin
            idx_s   = {IDX_W{1'b0}};
            state_s = D_IDLE;
          end else begin
            idx_s   = idx_r + IDX_W'(1);
            state_s = D_STREAM;
          end
        end else begin
          idx_s   = idx_r;
          state_s = D_STREAM;
        end
      end
      default: begin
        idx_s   = {IDX_W{1'b0}};
        state_s = D_IDLE;
      end
    endcase
  end

  // State and element index registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= D_IDLE;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Snapshot of C; later changes on c_data_in cannot disturb the stream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_r <= {(ELEMS*DATA_WIDTH_FINAL){1'b0}};
    end else if (load_s) begin
      shadow_r <= c_data_in;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign streaming_s = (state_r == D_STREAM);

  // Output decode from registered state/idx/shadow; everything is forced to
  // zero outside STREAM so idle and reset show all-zero outputs.
  always_comb begin
    c_re            = (state_r == D_READ);
    blk_rdy         = (state_r == D_CAPTURE);
    busy            = (state_r != D_IDLE);
    stream.out_val  = streaming_s;
    if (streaming_s) begin
      stream.out_data = shadow_r[int'(idx_r)*DATA_WIDTH_FINAL +: DATA_WIDTH_FINAL];
      stream.out_idx  = idx_r;
      stream.out_last = (idx_r == LAST_IDX);
    end else begin
      stream.out_data = {DATA_WIDTH_FINAL{1'b0}};
      stream.out_idx  = {IDX_W{1'b0}};
      stream.out_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: a 2x2 instance checked through a
// scoreboard of expected beats, plus a 4x4 instance for the default size.
module tb_mac_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        blk_val, blk_rdy, c_re, busy;
  logic [63:0] c_data;

  logic         blk_val4, blk_rdy4, c_re4, busy4;
  logic [255:0] c_data4;

  mac_result_drain_if #(.DATA_WIDTH(16), .IDX_W(2)) s2 ();
  mac_result_drain_if #(.DATA_WIDTH(16), .IDX_W(4)) s4 ();

  mac_result_drain #(.param_M(2), .param_N(2), .DATA_WIDTH_FINAL(16)) u_dut (
    .clk(clk), .rstn(rstn), .blk_val(blk_val), .blk_rdy(blk_rdy), .c_re(c_re),
    .c_data_in(c_data), .busy(busy), .stream(s2.master)
  );

  mac_result_drain #(.param_M(4), .param_N(4), .DATA_WIDTH_FINAL(16)) u_dut4 (
    .clk(clk), .rstn(rstn), .blk_val(blk_val4), .blk_rdy(blk_rdy4), .c_re(c_re4),
    .c_data_in(c_data4), .busy(busy4), .stream(s4.master)
  );

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_drain(input logic [63:0] c);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.idx  = 2'(i);
      e.data = c[i*16 +: 16];
      e.last = (i == 3);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_blk();
    @(posedge clk); #1 blk_val = 1'b1;
    @(posedge clk); #1 blk_val = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: scoreboard compare on every accepted beat, stability under stall.
  int          beats = 0;
  int          rdy_pulses = 0;
  logic        hold_chk = 1'b0;
  logic [15:0] hold_d;
  logic [1:0]  hold_i;
  logic        hold_l;

  always @(negedge clk) begin
    if (!rstn) begin
      hold_chk <= 1'b0;
    end else begin
      if (hold_chk) begin
        check("hold_val",  64'(s2.out_val),  64'd1);
        check("hold_data", 64'(s2.out_data), 64'(hold_d));
        check("hold_idx",  64'(s2.out_idx),  64'(hold_i));
        check("hold_last", 64'(s2.out_last), 64'(hold_l));
      end
      if (s2.out_val && s2.out_rdy) begin
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("beat_idx",  64'(s2.out_idx),  64'(e.idx));
          check("beat_data", 64'(s2.out_data), 64'(e.data));
          check("beat_last", 64'(s2.out_last), 64'(e.last));
        end
        beats <= beats + 1;
      end
      if (blk_rdy) rdy_pulses <= rdy_pulses + 1;
      hold_chk <= s2.out_val && !s2.out_rdy;
      hold_d   <= s2.out_data;
      hold_i   <= s2.out_idx;
      hold_l   <= s2.out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] C_BASIC = 64'h0004_0003_0002_0001;
  localparam logic [6:0]  BP_PAT  = 7'b1101001;

  initial begin
    int b0, r0, k;
    rstn = 1'b0; blk_val = 1'b0; s2.out_rdy = 1'b0; c_data = 64'd0;
    blk_val4 = 1'b0; s4.out_rdy = 1'b0; c_data4 = 256'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_val",  64'(s2.out_val),  64'd0);
    check("rst_busy", 64'(busy),        64'd0);
    check("rst_rdy",  64'(blk_rdy),     64'd0);
    check("rst_re",   64'(c_re),        64'd0);
    check("rst_idx",  64'(s2.out_idx),  64'd0);
    check("rst_data", 64'(s2.out_data), 64'd0);
    check("rst_last", 64'(s2.out_last), 64'd0);
    check("rst4_val", 64'(s4.out_val),  64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Basic drain with a free-running consumer.
    c_data = C_BASIC; s2.out_rdy = 1'b1;
    push_drain(C_BASIC);
    pulse_blk();
    @(negedge clk);
    check("basic_re",     64'(c_re),       64'd1);
    check("basic_rdy0",   64'(blk_rdy),    64'd0);
    @(negedge clk);
    check("basic_re_off", 64'(c_re),       64'd0);
    check("basic_rdy",    64'(blk_rdy),    64'd1);
    check("basic_noval",  64'(s2.out_val), 64'd0);
    @(negedge clk);
    check("basic_first",  64'(s2.out_val), 64'd1);
    wait_idle("basic", 20);

    // Backpressure pattern applied from the first valid cycle.
    s2.out_rdy = 1'b0;
    c_data = 64'h1234_BEEF_00FF_8001;
    push_drain(64'h1234_BEEF_00FF_8001);
    b0 = beats;
    pulse_blk();
    k = 0;
    while (!s2.out_val && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_started", 64'(s2.out_val), 64'd1);
    for (int i = 0; i < 7; i++) begin
      s2.out_rdy = BP_PAT[i];
      @(posedge clk); #1;
    end
    s2.out_rdy = 1'b0;
    @(negedge clk);
    check("bp_beats", 64'(beats - b0), 64'd4);
    wait_idle("bp", 5);
    s2.out_rdy = 1'b1;

    // Memory data changes right after capture; the snapshot must win.
    c_data = C_BASIC;
    push_drain(C_BASIC);
    pulse_blk();
    @(negedge clk);
    @(negedge clk);
    check("iso_rdy", 64'(blk_rdy), 64'd1);
    @(posedge clk); #1 c_data = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_idle("iso", 20);
    c_data = C_BASIC;

    // blk_val held high: one ack per drain, back-to-back restart.
    r0 = rdy_pulses;
    push_drain(C_BASIC);
    push_drain(C_BASIC);
    @(posedge clk); #1 blk_val = 1'b1;
    k = 0;
    @(negedge clk);
    while (!(s2.out_val && s2.out_last) && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("b2b_last_seen", 64'(s2.out_last), 64'd1);
    @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("b2b_re",   64'(c_re), 64'd1);
    @(posedge clk); #1 blk_val = 1'b0;
    wait_idle("b2b", 20);
    check("b2b_acks", 64'(rdy_pulses - r0), 64'd2);

    // Reset after the second beat, then a fresh drain.
    push_drain(C_BASIC);
    b0 = beats;
    pulse_blk();
    k = 0;
    while ((beats - b0) < 2 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_beats", 64'(beats - b0), 64'd2);
    rstn = 1'b0;
    #1;
    check("mid_val",  64'(s2.out_val), 64'd0);
    check("mid_busy", 64'(busy),       64'd0);
    check("mid_idx",  64'(s2.out_idx), 64'd0);
    sb.delete();
    @(posedge clk); #1 rstn = 1'b1;
    c_data = 64'hA5A5_0000_FFFF_7777;
    push_drain(64'hA5A5_0000_FFFF_7777);
    pulse_blk();
    wait_idle("post_rst", 20);

    // Default 4x4 geometry.
    for (int i = 0; i < 16; i++) c_data4[i*16 +: 16] = 16'hA000 ^ 16'(i * 273);
    s4.out_rdy = 1'b1;
    @(posedge clk); #1 blk_val4 = 1'b1;
    @(posedge clk); #1 blk_val4 = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (s4.out_val) begin
        check("d4_idx",  64'(s4.out_idx),  64'(k));
        check("d4_data", 64'(s4.out_data), 64'(16'hA000 ^ 16'(k * 273)));
        check("d4_last", 64'(s4.out_last), 64'(k == 15));
        if (s4.out_last) check("d4_top", 64'(s4.out_data), 64'(c_data4[255:240]));
        k++;
      end
      if (!busy4 && k > 0) break;
    end
    check("d4_beats", 64'(k), 64'd16);
    check("d4_idle",  64'(busy4), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
